ccmp_block_sched: RTL
=====================

CCMP_BLOCK_SCHED -- requirements
Module: ccmp_block_sched

Interface
REQ-001 Parameter LEN_W, default 16, payload byte-length width.
REQ-002 Parameter TMO_CYC, default 255, AES watchdog limit in cycles; used only with the Configuration feature.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 Port pClk, input, 1 -- baseband clock; all logic on its rising edge.
REQ-005 Port sRst, input, 1 -- synchronous active-high reset.
REQ-006 Port start_p, input, 1 -- one-cycle frame start pulse.
REQ-007 Port payloadByteLen, input, LEN_W -- payload bytes, sampled on start_p.
REQ-008 Port abort_p, input, 1 -- Tx/Rx error pulse.
REQ-009 Port aesReady, input, 1 -- AES core idle, may accept a request.
REQ-010 Port aesDone_p, input, 1 -- AES result valid pulse.
REQ-011 Port outBusy, input, 1 -- output byte-serialiser still draining a block.
REQ-012 Port aesStart_p, output, 1 -- AES request pulse.
REQ-013 Port aesMode, output, 2 -- 00 MAC (B0/Bi), 01 CTR payload, 10 CTR A0 (MIC).
REQ-014 Port ctrIdx, output, LEN_W-4 -- current counter-block index, starting at 1.
REQ-015 Port payloadEnd_p, output, 1 -- final payload block issued.
REQ-016 Port payloadLen, output, 4 -- bytes valid in final block; 0 encodes 16.
REQ-017 Port micValid_p, output, 1 -- encrypted MIC ready.
REQ-018 Port busy, output, 1 -- state is not IDLE.
REQ-019 Port done_p, output, 1 -- frame sequence complete.
REQ-020 Port timeoutErr_p, output, 1 -- AES watchdog expiry.

Function
REQ-021 States: IDLE, MAC_B0, CTR_BLK, WAIT_OUT, MAC_BLK, CTR_A0, DONE.
- Each AES-issuing state asserts aesStart_p for exactly one cycle, in the first cycle in that state with aesReady=1.
- It then waits for aesDone_p; aesStart_p is never reasserted before aesDone_p.
REQ-022 IDLE + start_p:
- Capture the length; set blocksLeft = ceil(len/16); set ctrIdx = 1.
- Go to MAC_B0.
- start_p is ignored while busy=1.
REQ-023 MAC_B0 done:
- If blocksLeft = 0, go to CTR_A0.
- Otherwise go to CTR_BLK.
REQ-024 CTR_BLK issue:
- Issue is gated additionally by outBusy=0.
- If blocksLeft = 1, pulse payloadEnd_p in the same cycle as aesStart_p, with payloadLen = len[3:0].
REQ-025 CTR_BLK done:
- Go to MAC_BLK.
- Decrement blocksLeft; increment ctrIdx (wraps modulo 2^(LEN_W-4)).
REQ-026 MAC_BLK done:
- If blocksLeft > 0, go to CTR_BLK.
- Otherwise go to WAIT_OUT.
REQ-027 WAIT_OUT: go to CTR_A0 when outBusy=0.
REQ-028 CTR_A0 done: pulse micValid_p for one cycle, then go to DONE.
REQ-029 DONE: pulse done_p for one cycle, then go to IDLE.
REQ-030 abort_p in any state:
- Go to IDLE next cycle; clear counters.
- Suppress any pulse output in that cycle.
- A following aesDone_p is ignored.
REQ-031 aesDone_p in a non-waiting state is ignored.
REQ-032 aesMode holds the code of the current state; it is 00 in IDLE.
REQ-033 Simultaneous events: abort_p wins over aesDone_p and start_p.

Reset
REQ-034 sRst=1 at a clock edge:
- State goes to IDLE.
- Counters, ctrIdx and payloadLen go to 0.
- All pulse outputs, busy and aesMode go to 0.
REQ-035 sRst mid-frame behaves as abort_p; the first frame after reset needs a new start_p.

Configuration
REQ-036 Macro CCMP_BLOCK_SCHED_TIMEOUT_EN.
- Defined: an 8-bit counter starts at each aesStart_p.
- It clears on aesDone_p.
- Reaching TMO_CYC pulses timeoutErr_p for one cycle and forces IDLE, as abort_p.
- Undefined: no counter; timeoutErr_p is tied to 0.

Verification
REQ-037 len=32, aesDone_p 3 cycles after each start -> mode sequence 00,01,00,01,00,10; payloadEnd_p with the 2nd CTR, payloadLen=0; micValid_p then done_p.
REQ-038 len=0 -> modes 00,10 only; no payloadEnd_p; micValid_p=1 once.
REQ-039 len=17, outBusy held 10 cycles after 1st CTR done -> 2nd CTR start delayed until outBusy=0; payloadLen=1.
REQ-040 abort_p during 2nd MAC_BLK, then late aesDone_p -> busy=0 next cycle; no micValid_p; new start_p accepted.
REQ-041 With macro defined, aesDone_p withheld 255 cycles -> timeoutErr_p=1 once, busy=0; without macro, timeoutErr_p stays 0.

Source files
------------

// File: rtl/ccmp_block_sched_if.sv
// CCM* block scheduler bus: frame control inputs, AES core handshake and
// output-serialiser status, with the scheduler on the master side.
interface ccmp_block_sched_if #(
  parameter int LEN_W = 16
);
  logic             start_p;
  logic [LEN_W-1:0] payloadByteLen;
  logic             abort_p;
  logic             aesReady;
  logic             aesDone_p;
  logic             outBusy;
  logic             aesStart_p;
  logic [1:0]       aesMode;
  logic [LEN_W-5:0] ctrIdx;
  logic             payloadEnd_p;
  logic [3:0]       payloadLen;
  logic             micValid_p;
  logic             busy;
  logic             done_p;
  logic             timeoutErr_p;

  modport master (
    input  start_p, payloadByteLen, abort_p, aesReady, aesDone_p, outBusy,
    output aesStart_p, aesMode, ctrIdx, payloadEnd_p, payloadLen,
           micValid_p, busy, done_p, timeoutErr_p
  );

  modport slave (
    output start_p, payloadByteLen, abort_p, aesReady, aesDone_p, outBusy,
    input  aesStart_p, aesMode, ctrIdx, payloadEnd_p, payloadLen,
           micValid_p, busy, done_p, timeoutErr_p
  );
endinterface

// File: rtl/ccmp_block_sched.sv
// CCM* block scheduler: orders B0/MAC, CTR payload and CTR A0 requests to one AES core.
// Optional AES watchdog enabled by defining CCMP_BLOCK_SCHED_TIMEOUT_EN.
module ccmp_block_sched #(
  parameter int LEN_W   = 16,
  parameter int TMO_CYC = 255
) (
  input logic                pClk,
  input logic                sRst,
  ccmp_block_sched_if.master bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] MAC_B0   = 3'd1;
  localparam logic [2:0] CTR_BLK  = 3'd2;
  localparam logic [2:0] WAIT_OUT = 3'd3;
  localparam logic [2:0] MAC_BLK  = 3'd4;
  localparam logic [2:0] CTR_A0   = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  localparam logic [LEN_W-4:0] ONE_BLK = (LEN_W-3)'(1);

  logic [2:0]       state;
  logic [2:0]       nextState;
  logic             waitDone;
  logic [LEN_W-4:0] blocksLeft;
  logic [LEN_W-4:0] blocksInit;
  logic [LEN_W-5:0] ctrIdxQ;
  logic [3:0]       lenLow;
  logic             issueState;
  logic             kill;
  logic             quiet;
  logic             startFire;
  logic             doneHit;
  logic             tmoHit;

  assign blocksInit = (LEN_W-3)'(({1'b0, bus.payloadByteLen} + (LEN_W+1)'(15)) >> 4);

  // waitDone marks an outstanding AES request; it blocks re-issue and qualifies aesDone_p
  assign issueState = (state == MAC_B0) || (state == CTR_BLK) ||
                      (state == MAC_BLK) || (state == CTR_A0);
  assign kill       = bus.abort_p || tmoHit;
  assign quiet      = sRst || kill;
  assign startFire  = issueState && !waitDone && bus.aesReady &&
                      ((state != CTR_BLK) || !bus.outBusy) && !quiet;
  assign doneHit    = waitDone && bus.aesDone_p && !quiet;

  always_comb begin
    nextState = state;
    if (kill) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:     if (bus.start_p) nextState = MAC_B0;
        MAC_B0:   if (doneHit) nextState = (blocksLeft == '0) ? CTR_A0 : CTR_BLK;
        CTR_BLK:  if (doneHit) nextState = MAC_BLK;
        MAC_BLK:  if (doneHit) nextState = (blocksLeft != '0) ? CTR_BLK : WAIT_OUT;
        WAIT_OUT: if (!bus.outBusy) nextState = CTR_A0;
        CTR_A0:   if (doneHit) nextState = DONE;
        DONE:     nextState = IDLE;
        default:  nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge pClk) begin
    if (sRst || kill) begin
      state      <= IDLE;
      waitDone   <= 1'b0;
      blocksLeft <= '0;
      ctrIdxQ    <= '0;
      lenLow     <= '0;
    end else begin
      state <= nextState;
      if (startFire) begin
        waitDone <= 1'b1;
      end else if (doneHit) begin
        waitDone <= 1'b0;
      end
      if ((state == IDLE) && bus.start_p) begin
        blocksLeft <= blocksInit;
        ctrIdxQ    <= (LEN_W-4)'(1);
        lenLow     <= bus.payloadByteLen[3:0];
      end else if ((state == CTR_BLK) && doneHit) begin
        blocksLeft <= blocksLeft - ONE_BLK;
        ctrIdxQ    <= ctrIdxQ + 1'b1;
      end
    end
  end

`ifdef CCMP_BLOCK_SCHED_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TMO_CYC);

  logic [7:0] tmoCnt;

  // tmoCnt equals the number of cycles elapsed since the outstanding request was issued
  assign tmoHit = waitDone && !bus.aesDone_p && (tmoCnt == TMO_LIM);

  always_ff @(posedge pClk) begin
    if (sRst) begin
      tmoCnt <= '0;
    end else if (startFire) begin
      tmoCnt <= 8'd1;
    end else if (!waitDone || bus.aesDone_p) begin
      tmoCnt <= '0;
    end else if (tmoCnt != TMO_LIM) begin
      tmoCnt <= tmoCnt + 8'd1;
    end
  end
`else
  // Watchdog compiled out; the limit stays referenced so the parameter list is unchanged.
  assign tmoHit = 1'b0 && (TMO_CYC > 0);
`endif

  always_comb begin
    case (state)
      CTR_BLK: bus.aesMode = 2'b01;
      CTR_A0:  bus.aesMode = 2'b10;
      default: bus.aesMode = 2'b00;
    endcase
  end

  assign bus.aesStart_p   = startFire;
  assign bus.payloadEnd_p = startFire && (state == CTR_BLK) && (blocksLeft == ONE_BLK);
  assign bus.payloadLen   = lenLow;
  assign bus.ctrIdx       = ctrIdxQ;
  assign bus.micValid_p   = doneHit && (state == CTR_A0);
  assign bus.busy         = (state != IDLE);
  assign bus.done_p       = (state == DONE) && !quiet;
  assign bus.timeoutErr_p = tmoHit && !sRst && !bus.abort_p;
endmodule
